apb_master_arb: RTL

Round-robin APB master that lets NREQ on-chip requesters share one APB slave port. Each request (read or write, one address, one data word) is accepted, arbitrated and driven as a standard SETUP/ACCESS APB transfer; the block waits for `pready`, applies a timeout, then returns read data and error status to the requester that issued the transfer. It sits between the requester logic and the 32-word APB register/memory slave.

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/apb_master_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master state encoding and default bus geometry
// used by both the master and the 32-word register/memory slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_AW = 5;
  localparam int APB_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting bit at or
// above ptr, wrapping around to bit 0.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  always_comb begin
    int idx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master: arbitrates NREQ requesters onto one APB port,
// one SETUP/ACCESS transfer at a time, with an optional ACCESS timeout.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DW-1:0]     prdata
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_t      state_reg, state_next;
  logic [PW-1:0]   owner_reg, owner_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;

  logic [NREQ-1:0] req_ready_next, rsp_valid_next;
  logic [DW-1:0]   rsp_rdata_next, pwdata_next;
  logic [AW-1:0]   paddr_next;
  logic            rsp_err_next, psel_next, penable_next, pwrite_next;

  logic [NREQ-1:0] grant;
  logic            any_grant;
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_wdata;
  logic            gnt_write;
  logic [PW-1:0]   ptr_after;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .any   (any_grant)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  // Grant is one-hot, so OR-ing the selected lanes forms the payload mux.
  always_comb begin
    gnt_idx   = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx   = gnt_idx | PW'(i);
        gnt_addr  = gnt_addr | addr_arr[i];
        gnt_wdata = gnt_wdata | wdata_arr[i];
        gnt_write = gnt_write | req_write[i];
      end
    end
  end

  assign ptr_after = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + PW'(1);

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    wait_cnt_next  = wait_cnt_reg;
    req_ready_next = '0;
    rsp_valid_next = '0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;
    psel_next      = psel;
    penable_next   = penable;
    pwrite_next    = pwrite;
    paddr_next     = paddr;
    pwdata_next    = pwdata;
    case (state_reg)
      IDLE: begin
        if (any_grant) begin
          req_ready_next = grant;
          owner_next     = gnt_idx;
          pwrite_next    = gnt_write;
          paddr_next     = gnt_addr;
          pwdata_next    = gnt_wdata;
          psel_next      = 1'b1;
          wait_cnt_next  = '0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_next                 = 1'b0;
          penable_next              = 1'b0;
          rsp_valid_next[owner_reg] = 1'b1;
          rsp_rdata_next            = pwrite ? '0 : prdata;
          rsp_err_next              = pslverr;
          ptr_next                  = ptr_after;
          state_next                = IDLE;
        end else if (TIMEOUT != 0 && wait_cnt_reg == CW'(TIMEOUT)) begin
          // Slave never answered: abandon the transfer with an error.
          psel_next                 = 1'b0;
          penable_next              = 1'b0;
          rsp_valid_next[owner_reg] = 1'b1;
          rsp_err_next              = 1'b1;
          ptr_next                  = ptr_after;
          state_next                = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      wait_cnt_reg <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      wait_cnt_reg <= wait_cnt_next;
      req_ready    <= req_ready_next;
      rsp_valid    <= rsp_valid_next;
      rsp_rdata    <= rsp_rdata_next;
      rsp_err      <= rsp_err_next;
      psel         <= psel_next;
      penable      <= penable_next;
      pwrite       <= pwrite_next;
      paddr        <= paddr_next;
      pwdata       <= pwdata_next;
    end
  end

endmodule
